// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the multicycle control unit: instruction fields, datapath
// select codes, fault codes and the control state enumeration.
package mc_control_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1000;

    localparam logic [1:0] SRC_REG   = 2'b00;
    localparam logic [1:0] SRC_SEXT  = 2'b01;
    localparam logic [1:0] SRC_ZEXT  = 2'b10;
    localparam logic [1:0] SRC_SHAMT = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
        S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_FAULT
    } state_t;

    // Successor of DECODE; unknown encodings land in FAULT.
    function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
        state_t nx;
        nx = S_FAULT;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLTU, FN_SLL, FN_SRL: nx = S_EXEC_R;
                    FN_JR:   nx = S_JUMP;
                    default: nx = S_FAULT;
                endcase
            end
            OP_J, OP_JAL:                               nx = S_JUMP;
            OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTIU, OP_LUI: nx = S_EXEC_I;
            OP_LW, OP_SW:                               nx = S_MEM_ADDR;
            OP_BEQ, OP_BNE:                             nx = S_BRANCH;
            default:                                    nx = S_FAULT;
        endcase
        return nx;
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Datapath/memory side of the control unit. master = control unit (drives
// controls), slave = datapath (drives IR fields and mem_ready).
interface mc_control_unit_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             mem_req;
    logic             iorD;
    logic             memWrite;
    logic             irWrite;
    logic             pcWrite;
    logic             regWrite;
    logic             branch;
    logic             condZero;
    logic [3:0]       ALU_Code;
    logic [1:0]       aluSrc;
    logic [1:0]       regDst;
    logic [1:0]       memToReg;
    logic [1:0]       pcSrc;
    logic             fault;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] instr_count;

    // A memory request is held while mem_req=1 and completes in the cycle mem_ready=1.
    modport master (
        input  opcode, funct, mem_ready,
        output mem_req, iorD, memWrite, irWrite, pcWrite, regWrite, branch, condZero,
               ALU_Code, aluSrc, regDst, memToReg, pcSrc, fault, fault_code, instr_count
    );
    modport slave (
        output opcode, funct, mem_ready,
        input  mem_req, iorD, memWrite, irWrite, pcWrite, regWrite, branch, condZero,
               ALU_Code, aluSrc, regDst, memToReg, pcSrc, fault, fault_code, instr_count
    );
endinterface

// File: rtl/mc_control_unit_alu_decoder.sv
// Combinational map from instruction fields to ALU operation and operand-B source.
module alu_decoder
    import mc_control_unit_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_code,
    output logic [1:0] alu_src
);
    always_comb begin
        alu_code = ALU_ADD;
        alu_src  = SRC_REG;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SUB:  alu_code = ALU_SUB;
                    FN_AND:  alu_code = ALU_AND;
                    FN_OR:   alu_code = ALU_OR;
                    FN_XOR:  alu_code = ALU_XOR;
                    FN_SLTU: alu_code = ALU_SLTU;
                    FN_SLL:  begin alu_code = ALU_SLL; alu_src = SRC_SHAMT; end
                    FN_SRL:  begin alu_code = ALU_SRL; alu_src = SRC_SHAMT; end
                    default: alu_code = ALU_ADD;
                endcase
            end
            OP_ADDIU:     begin alu_code = ALU_ADD;  alu_src = SRC_SEXT; end
            OP_SLTIU:     begin alu_code = ALU_SLTU; alu_src = SRC_SEXT; end
            OP_ANDI:      begin alu_code = ALU_AND;  alu_src = SRC_ZEXT; end
            OP_ORI:       begin alu_code = ALU_OR;   alu_src = SRC_ZEXT; end
            OP_LUI:       begin alu_code = ALU_LUI;  alu_src = SRC_ZEXT; end
            OP_LW, OP_SW: begin alu_code = ALU_ADD;  alu_src = SRC_SEXT; end
            OP_BEQ, OP_BNE: alu_code = ALU_SUB;
            default:      alu_code = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control FSM with memory-wait timeout, sticky fault and
// retired-instruction counter.
module mc_control_unit
    import mc_control_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    mc_control_unit_if.master  bus,
    output state_t             dbg_state
);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t             state, state_nx;
    logic [1:0]         fault_code_q, fault_code_nx;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   count;
    logic [3:0]         dec_alu;
    logic [1:0]         dec_src;
    logic               mem_state;
    logic               timeout;

    alu_decoder u_alu_decoder (
        .opcode   (bus.opcode),
        .funct    (bus.funct),
        .alu_code (dec_alu),
        .alu_src  (dec_src)
    );

    assign mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // A late mem_ready on the final allowed cycle still completes the access.
    assign timeout   = mem_state && !bus.mem_ready &&
                       (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_FETCH;
            fault_code_q <= FAULT_NONE;
            wait_cnt     <= '0;
            count        <= '0;
        end else begin
            state        <= state_nx;
            fault_code_q <= fault_code_nx;
            if ((state_nx != state) &&
                ((state_nx == S_FETCH) || (state_nx == S_MEM_RD) || (state_nx == S_MEM_WR)))
                wait_cnt <= '0;
            else if (mem_state && !bus.mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            if ((state_nx == S_FETCH) && (state != S_FETCH))
                count <= count + 1'b1;
        end
    end

    always_comb begin
        state_nx      = state;
        fault_code_nx = fault_code_q;
        case (state)
            S_FETCH: begin
                if (bus.mem_ready) state_nx = S_DECODE;
                else if (timeout) begin state_nx = S_FAULT; fault_code_nx = FAULT_TIMEOUT; end
            end
            S_DECODE: begin
                state_nx = decode_next(bus.opcode, bus.funct);
                if (state_nx == S_FAULT) fault_code_nx = FAULT_ILLEGAL;
            end
            S_EXEC_R, S_EXEC_I: state_nx = S_WB_ALU;
            S_MEM_ADDR:         state_nx = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (bus.mem_ready) state_nx = S_WB_MEM;
                else if (timeout) begin state_nx = S_FAULT; fault_code_nx = FAULT_TIMEOUT; end
            end
            S_MEM_WR: begin
                if (bus.mem_ready) state_nx = S_FETCH;
                else if (timeout) begin state_nx = S_FAULT; fault_code_nx = FAULT_TIMEOUT; end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_nx = S_FETCH;
            S_FAULT:  state_nx = S_FAULT;
            default:  state_nx = S_FAULT;
        endcase
    end

    always_comb begin
        bus.mem_req  = 1'b0;
        bus.iorD     = 1'b0;
        bus.memWrite = 1'b0;
        bus.irWrite  = 1'b0;
        bus.pcWrite  = 1'b0;
        bus.regWrite = 1'b0;
        bus.branch   = 1'b0;
        bus.condZero = 1'b0;
        bus.ALU_Code = ALU_AND;
        bus.aluSrc   = SRC_REG;
        bus.regDst   = DST_RT;
        bus.memToReg = M2R_ALU;
        bus.pcSrc    = PC_PLUS4;
        bus.fault    = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                bus.irWrite = bus.mem_ready;
                bus.pcWrite = bus.mem_ready;
            end
            S_EXEC_R, S_EXEC_I, S_MEM_ADDR: begin
                bus.ALU_Code = dec_alu;
                bus.aluSrc   = dec_src;
            end
            S_WB_ALU: begin
                bus.regWrite = 1'b1;
                bus.regDst   = (bus.opcode == OP_RTYPE) ? DST_RD : DST_RT;
            end
            S_MEM_RD: begin
                bus.mem_req = 1'b1;
                bus.iorD    = 1'b1;
            end
            S_WB_MEM: begin
                bus.regWrite = 1'b1;
                bus.memToReg = M2R_MEM;
            end
            S_MEM_WR: begin
                bus.mem_req  = 1'b1;
                bus.iorD     = 1'b1;
                bus.memWrite = 1'b1;
            end
            S_BRANCH: begin
                bus.ALU_Code = dec_alu;
                bus.aluSrc   = dec_src;
                bus.branch   = 1'b1;
                bus.pcSrc    = PC_BRANCH;
                bus.condZero = (bus.opcode == OP_BEQ);
            end
            S_JUMP: begin
                bus.pcWrite = 1'b1;
                bus.pcSrc   = (bus.opcode == OP_RTYPE) ? PC_RS : PC_JUMP;
                if (bus.opcode == OP_JAL) begin
                    bus.regDst   = DST_RA;
                    bus.memToReg = M2R_PC4;
                    bus.regWrite = 1'b1;
                end
            end
            S_FAULT: bus.fault = 1'b1;
            default: bus.fault = 1'b0;
        endcase
    end

    assign bus.fault_code  = fault_code_q;
    assign bus.instr_count = count;
    assign dbg_state       = state;

endmodule
